// File: rtl/riscv_icache_pkg.sv
// Shared geometry, state encoding and line-address layout for the
// instruction-cache refill controller.
package riscv_icache_pkg;

    localparam int DATA_WIDTH  = 128;
    localparam int CACHE_SIZE  = 4 * (2 ** 10);
    localparam int MEM_SIZE    = 4 * CACHE_SIZE;
    localparam int DATAPBLOCK  = 16;
    localparam int CACHE_DEPTH = CACHE_SIZE / DATAPBLOCK;
    localparam int ADDR        = $clog2(MEM_SIZE);
    localparam int BYTE_OFF    = $clog2(DATAPBLOCK);
    localparam int INDEX       = $clog2(CACHE_DEPTH);
    localparam int TAG         = ADDR - BYTE_OFF - INDEX;
    localparam int S_ADDR      = ADDR - BYTE_OFF;
    localparam int CNT_W       = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MISS  = 2'd1,
        FILL  = 2'd2,
        FLUSH = 2'd3
    } icache_state_t;

    typedef struct packed {
        logic [TAG-1:0]   tag;
        logic [INDEX-1:0] index;
    } line_addr_t;

endpackage

// File: rtl/riscv_icache_refill_ctrl_flush_cnt.sv
// Line index walker for the invalidate-all sequence; cleared when a walk
// starts and wrapped back to zero on its final line.
module riscv_icache_flush_cnt
    import riscv_icache_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             en_i,
    output logic [INDEX-1:0] idx_o,
    output logic             last_o
);

    logic [INDEX-1:0] cnt_q, cnt_d;

    assign last_o = (cnt_q == INDEX'(CACHE_DEPTH - 1));
    assign idx_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = last_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/riscv_icache_refill_ctrl.sv
// I-cache miss/refill controller: stalls fetch on a miss, reads the line from
// instruction RAM, writes line and tag into the arrays, and runs fence.i walks.
//
// state | meaning
// IDLE  | lookups served from the cache, watching for misses and flushes
// MISS  | line read outstanding, waiting for mem_ready
// FILL  | one settle cycle after the array write
// FLUSH | clearing one valid bit per cycle across all lines
module riscv_icache_refill_ctrl
    import riscv_icache_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req_i,
    input  logic [ADDR-1:0]   cpu_addr_i,
    input  logic              tag_hit_i,
    input  logic              flush_req_i,
    output logic              stall_o,
    output logic              mem_rden_o,
    output logic [S_ADDR-1:0] mem_addr_o,
    input  logic              mem_ready_i,
    output logic              data_wr_en_o,
    output logic              tag_wr_en_o,
    output logic [INDEX-1:0]  wr_index_o,
    output logic [TAG-1:0]    wr_tag_o,
    output logic              wr_valid_o,
    output logic              flush_done_o,
    output logic [CNT_W-1:0]  miss_count_o
);

    icache_state_t    state_q, state_d;
    line_addr_t       line_q;
    logic             mem_rden_q;
    logic             flush_pend_q, flush_pend_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
    logic             flush_any, miss_lookup, flush_start, flush_last;
    logic [INDEX-1:0] flush_idx;
    logic             unused_offset;

    assign flush_any     = flush_req_i | flush_pend_q;
    assign miss_lookup   = cpu_req_i & ~tag_hit_i;
    assign flush_start   = (state_d == FLUSH) && (state_q != FLUSH);
    assign unused_offset = ^cpu_addr_i[BYTE_OFF-1:0];

    riscv_icache_flush_cnt u_flush_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (flush_start),
        .en_i    (state_q == FLUSH),
        .idx_o   (flush_idx),
        .last_o  (flush_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A flush always wins over a miss seen in the same IDLE cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (flush_any) begin
                    state_d = FLUSH;
                end else if (miss_lookup) begin
                    state_d = MISS;
                end
            end
            MISS: begin
                if (mem_ready_i) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                state_d = flush_any ? FLUSH : IDLE;
            end
            FLUSH: begin
                if (flush_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall_o      = (state_q != IDLE) | flush_any | miss_lookup;
        mem_rden_o   = mem_rden_q;
        mem_addr_o   = line_q;
        data_wr_en_o = 1'b0;
        tag_wr_en_o  = 1'b0;
        wr_index_o   = line_q.index;
        wr_tag_o     = line_q.tag;
        wr_valid_o   = 1'b0;
        flush_done_o = 1'b0;
        miss_count_o = miss_cnt_q;
        unique case (state_q)
            MISS: begin
                data_wr_en_o = mem_ready_i;
                tag_wr_en_o  = mem_ready_i;
                wr_valid_o   = 1'b1;
            end
            FLUSH: begin
                tag_wr_en_o  = 1'b1;
                wr_index_o   = flush_idx;
                wr_tag_o     = '0;
                flush_done_o = flush_last;
            end
            default: ;
        endcase
    end

    // Repeated flush pulses collapse into the single pending bit.
    always_comb begin
        flush_pend_d = flush_start ? 1'b0 : flush_any;
        miss_cnt_d   = miss_cnt_q;
        if ((state_q == IDLE) && (state_d == MISS) && (miss_cnt_q != '1)) begin
            miss_cnt_d = miss_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q       <= '0;
            mem_rden_q   <= 1'b0;
            flush_pend_q <= 1'b0;
            miss_cnt_q   <= '0;
        end else begin
            if ((state_q == IDLE) && (state_d == MISS)) begin
                line_q <= line_addr_t'(cpu_addr_i[ADDR-1:BYTE_OFF]);
            end
            mem_rden_q   <= (state_d == MISS);
            flush_pend_q <= flush_pend_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

endmodule
